// File: rtl/spi_shift_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine_if
// Description : Bundle of request, status and SPI-pin signals between the
//               register file / SPI header and the byte-wide shift engine.
//               master : register-file and device side
//                        (drives requests and MISO, observes pins and status)
//               slave  : the shift engine itself
//               Signals: START, READ, TXDATA[7:0], SLOW, CS_REQ, MISO (to engine)
//                        SCK, MOSI, CS, BUSY, DONE, RXDATA[7:0], OVERRUN (from engine)
// Revision    : 1.0  initial release
// ============================================================================
interface spi_shift_engine_if;
    logic       START;
    logic       READ;
    logic [7:0] TXDATA;
    logic       SLOW;
    logic       CS_REQ;
    logic       MISO;
    logic       SCK;
    logic       MOSI;
    logic       CS;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RXDATA;
    logic       OVERRUN;

    modport master (
        output START, READ, TXDATA, SLOW, CS_REQ, MISO,
        input  SCK, MOSI, CS, BUSY, DONE, RXDATA, OVERRUN
    );

    modport slave (
        input  START, READ, TXDATA, SLOW, CS_REQ, MISO,
        output SCK, MOSI, CS, BUSY, DONE, RXDATA, OVERRUN
    );
endinterface
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : Full-duplex, mode-0, MSB-first byte SPI master. One transfer
//               request at a time; programmable SCK half-period selected per
//               transfer (FAST_DIV / SLOW_DIV). All outputs registered.
// Ports       : CLKOSC - sole clock, rising edge
//               RST    - synchronous, active-low reset
//               bus    - spi_shift_engine_if.slave (request, status, SPI pins)
// Parameters  : FAST_DIV - SCK half-period in clocks when SLOW=0 (1..255)
//               SLOW_DIV - SCK half-period in clocks when SLOW=1 (1..255)
// Revision    : 1.0  initial release
// ============================================================================
module spi_shift_engine #(
    parameter int FAST_DIV = 2,
    parameter int SLOW_DIV = 100
) (
    input  logic                  CLKOSC,
    input  logic                  RST,
    spi_shift_engine_if.slave     bus
);

    localparam logic [7:0] c_FAST_DIV = 8'(FAST_DIV);
    localparam logic [7:0] c_SLOW_DIV = 8'(SLOW_DIV);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOW  = 2'd1;
    localparam logic [1:0] c_HIGH = 2'd2;
    localparam logic [1:0] c_TAIL = 2'd3;

    logic [1:0] state_q,  state_d;
    logic [7:0] phase_q,  phase_d;
    logic [2:0] bit_q,    bit_d;
    logic [7:0] shift_q,  shift_d;
    logic [7:0] div_q,    div_d;
    logic [7:0] rx_q,     rx_d;
    logic       ovr_q,    ovr_d;
    logic       done_d;
    logic       sck_d,    mosi_d,   cs_d,  busy_d;
    logic       sck_q,    mosi_q,   cs_q,  busy_q, done_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
        rx_d    = rx_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (bus.START) begin
                    shift_d = bus.READ ? 8'hFF : bus.TXDATA;
                    div_d   = bus.SLOW ? c_SLOW_DIV : c_FAST_DIV;
                    phase_d = div_d - 8'd1;
                    bit_d   = 3'd7;
                    ovr_d   = 1'b0;
                    state_d = c_LOW;
                end
            end
            c_LOW: begin
                if (phase_q == 8'd0) begin
                    phase_d = div_q - 8'd1;
                    state_d = c_HIGH;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            c_HIGH: begin
                if (phase_q == 8'd0) begin
                    // Edge that drops SCK: the slave still holds the bit here.
                    shift_d = {shift_q[6:0], bus.MISO};
                    phase_d = div_q - 8'd1;
                    if (bit_q == 3'd0) begin
                        state_d = c_TAIL;
                    end else begin
                        bit_d   = bit_q - 3'd1;
                        state_d = c_LOW;
                    end
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            default: begin // c_TAIL
                if (phase_q == 8'd0) begin
                    rx_d    = shift_q;
                    done_d  = 1'b1;
                    state_d = c_IDLE;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
        endcase

        // A request arriving mid-transfer is dropped but remembered.
        if (bus.START && (state_q != c_IDLE)) begin
            ovr_d = 1'b1;
        end

        // Pin values are decoded from the upcoming state so they leave flops.
        sck_d  = (state_d == c_HIGH);
        // shift_q is frozen throughout LOW/HIGH of a bit, so MOSI cannot move
        // while SCK is high.
        mosi_d = ((state_d == c_LOW) || (state_d == c_HIGH)) ? shift_d[7] : 1'b1;
        // CS is frozen for the whole transfer and tracks CS_REQ only in IDLE.
        cs_d   = (state_q == c_IDLE) ? bus.CS_REQ : cs_q;
        busy_d = (state_d != c_IDLE);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLKOSC) begin
        if (!RST) begin
            state_q <= c_IDLE;
            phase_q <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'hFF;
            div_q   <= c_FAST_DIV;
            rx_q    <= 8'hFF;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            rx_q    <= rx_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.SCK     = sck_q;
    assign bus.MOSI    = mosi_q;
    assign bus.CS      = cs_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.RXDATA  = rx_q;
    assign bus.OVERRUN = ovr_q;

endmodule
`default_nettype wire
